mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between both caches' memory-side interfaces and the memory model.
- Serialises line transfers: one outstanding transaction at a time.
- Round-robin on simultaneous requests so neither fetch nor load/store can starve.

Parameters:
- ADDR_W, 32, address width on all ports.
- LINE_W, 128, width of one cache-line transfer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_read  in  1  I-cache line read request; held until ic_ready.
- ic_addr  in  ADDR_W  I-cache line address.
- ic_rdata  out  LINE_W  line returned to I-cache.
- ic_ready  out  1  one-cycle completion pulse to I-cache.
- dc_read  in  1  D-cache line read request; held until dc_ready.
- dc_write  in  1  D-cache line write-back request; held until dc_ready.
- dc_addr  in  ADDR_W  D-cache line address.
- dc_wdata  in  LINE_W  write-back line.
- dc_rdata  out  LINE_W  line returned to D-cache.
- dc_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read command, level.
- mem_write  out  1  memory write command, level.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, one-cycle pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- Register last_grant: 0 = I, 1 = D.
- Reset (reset=0), asynchronous:
  - state=IDLE, last_grant=0.
  - All outputs 0, including ic_rdata, dc_rdata, mem_addr and mem_wdata.
  - An in-flight memory command is dropped immediately; no ready pulse is issued after reset release.
- IDLE:
  - dc_req = dc_read|dc_write.
  - Only ic_read -> BUSY_I. Only dc_req -> BUSY_D.
  - Both pending -> grant the port not served last: last_grant=0 -> BUSY_D; last_grant=1 -> BUSY_I.
  - On the grant edge, latch addr into mem_addr; for a D write also latch dc_wdata into mem_wdata and the read/write type.
- Write precedence: dc_read and dc_write both high is treated as a write.
- BUSY_x:
  - mem_read/mem_write asserted every cycle, addr/data stable.
  - Requester inputs are ignored, so changes and deassertion mid-transaction have no effect; the transaction completes.
- On mem_ready while in BUSY_x:
  - Next edge: mem_read/mem_write=0.
  - For reads, the port's rdata register <= mem_rdata.
  - Port ready=1 for exactly one cycle; last_grant updated; state -> RELEASE.
- RELEASE: one cycle, no grant evaluated (requester drops its request on seeing ready), then -> IDLE.
- Latency:
  - Request visible in IDLE at edge N -> mem command high from cycle N+1.
  - mem_ready at edge M -> port ready and rdata valid in cycle M+1.
  - Back-to-back grants are spaced by at least RELEASE + IDLE (2 cycles).
- ic_rdata/dc_rdata hold their value until the next read completion on that port; a write completion leaves dc_rdata unchanged.
- mem_ready in IDLE or RELEASE is ignored.
- ic_ready and dc_ready are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
1. Reset mid-transaction: assert reset while in BUSY_D with mem_write=1 -> mem_write=0 in the same cycle (asynchronous); after release, no dc_ready pulse, state IDLE.
2. Single I read: ic_read=1, ic_addr=0x0000_0040; memory returns mem_ready 4 cycles after the command with mem_rdata=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D -> mem_read high for 4 cycles, mem_addr=0x40; ic_ready pulses one cycle with that ic_rdata; dc_ready stays 0.
3. Simultaneous requests after reset: ic_read=1 (addr 0x100) and dc_read=1 (addr 0x200) held -> D served first (mem_addr=0x200); then, after a 2-cycle gap, I is served (mem_addr=0x100).
4. Starvation check: dc_read re-asserted immediately after each dc_ready while ic_read is held -> grants alternate D, I, D, I; I waits at most one D transaction.
5. Write-back: dc_write=1, dc_addr=0x80, dc_wdata=0x11..11, with dc_wdata changed to 0x22..22 during BUSY -> mem_write=1, mem_wdata stays 0x11..11; dc_ready pulses; dc_rdata unchanged.
6. Spurious and late-drop cases: mem_ready pulsed in IDLE -> no ready output and state stays IDLE; ic_read dropped during BUSY_I -> the transaction still completes and ic_ready pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single main-memory port between the instruction cache (read
// only) and the data cache (read / write-back). Exactly one line transfer is
// in flight at a time. When both caches are waiting, the grant goes to the
// port that was not served last, so neither side can starve.
//
// Ports
//   clk, reset         system clock (rising edge), async active-low reset
//   ic_read/ic_addr    I-cache line read request, held until ic_ready
//   ic_rdata/ic_ready  returned line and one-cycle completion pulse
//   dc_read/dc_write   D-cache read / write-back request, held until dc_ready
//   dc_addr/dc_wdata   D-cache line address and write-back data
//   dc_rdata/dc_ready  returned line and one-cycle completion pulse
//   mem_read/mem_write level command to memory, held until mem_ready
//   mem_addr/mem_wdata address and write data, stable while commanded
//   mem_rdata/mem_ready memory read data and one-cycle completion
//   busy               high whenever a transfer or its release cycle is active
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer; evaluate requests and grant one
// BUSY_I  | I-cache line read commanded, waiting for mem_ready
// BUSY_D  | D-cache read or write-back commanded, waiting for mem_ready
// RELEASE | ready pulse cycle; requester drops its request, no grant

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_q;
  logic                last_grant_q;  // 0 = I served last, 1 = D served last
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic [LINE_W-1:0]   ic_rdata_q;
  logic [LINE_W-1:0]   dc_rdata_q;
  logic                ic_ready_q;
  logic                dc_ready_q;

  logic dc_req;
  logic grant_i;

  assign dc_req  = dc_read | dc_write;
  // I wins when it is alone, or when both wait and D was served last.
  assign grant_i = ic_read & (~dc_req | last_grant_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_ready_q   <= 1'b0;
      dc_ready_q   <= 1'b0;
    end else begin
      // ready outputs are single-cycle pulses
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q    <= BUSY_I;
            mem_addr_q <= ic_addr;
            mem_read_q <= 1'b1;
          end else if (dc_req) begin
            state_q    <= BUSY_D;
            mem_addr_q <= dc_addr;
            // a write takes precedence when both D strobes are high
            if (dc_write) begin
              mem_write_q <= 1'b1;
              mem_wdata_q <= dc_wdata;
            end else begin
              mem_read_q  <= 1'b1;
            end
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read_q   <= 1'b0;
            ic_rdata_q   <= mem_rdata;
            ic_ready_q   <= 1'b1;
            last_grant_q <= 1'b0;
            state_q      <= RELEASE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            // only a read updates the returned line; a write leaves it alone
            if (mem_read_q) begin
              dc_rdata_q <= mem_rdata;
            end
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            dc_ready_q   <= 1'b1;
            last_grant_q <= 1'b1;
            state_q      <= RELEASE;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ic_rdata  = ic_rdata_q;
  assign ic_ready  = ic_ready_q;
  assign dc_rdata  = dc_rdata_q;
  assign dc_ready  = dc_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ic_read = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [LW-1:0] ic_rdata;
  logic          ic_ready;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic [LW-1:0] dc_rdata;
  logic          dc_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  typedef struct {
    bit            port;   // 0 = I, 1 = D
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit            ic_r;
    bit            dc_r;
    bit            dc_w;
    logic [AW-1:0] ic_a;
    logic [AW-1:0] dc_a;
    logic [LW-1:0] wd;
    int            lat;
    bit            d_first;
  } vec_t;

  txn_t exp_q[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 3;
  bit   spur_req = 1'b0;
  logic [LW-1:0] ic_model = '0;
  logic [LW-1:0] dc_model = '0;

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_0040) return 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1234};
  endfunction

  task automatic push(input bit port, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    txn_t t;
    t.port = port; t.wr = wr; t.addr = a; t.wdata = wd;
    exp_q.push_back(t);
  endtask

  // Memory responder and output monitor, all in one negedge process.
  logic cmd, prev_cmd = 1'b0;
  int   cnt = 0, cmd_len = 0, gap = 0;
  bit   first_cmd = 1'b1;
  txn_t t_mon;

  initial forever begin
    @(negedge clk);
    mem_ready = 1'b0;
    if (!reset) begin
      cnt = 0; cmd_len = 0; gap = 0; prev_cmd = 1'b0; first_cmd = 1'b1;
      ic_model = '0; dc_model = '0;
      continue;
    end
    cmd = mem_read | mem_write;
    if (cmd && !prev_cmd) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_unexpected: got command addr %h expected none", mem_addr);
      end else begin
        chka("cmd_addr", mem_addr, exp_q[0].addr);
        chkb("cmd_write", mem_write, exp_q[0].wr);
        chkb("cmd_read", mem_read, !exp_q[0].wr);
        if (!first_cmd) begin
          checks++;
          if (gap < 2) begin
            errors++;
            $display("FAIL grant_gap: got %0d idle cycles expected >= 2", gap);
          end
        end
      end
      first_cmd = 1'b0;
      cnt = 0;
    end
    if (cmd) begin
      cnt++;
      if (exp_q.size() > 0) begin
        chka("addr_stable", mem_addr, exp_q[0].addr);
        if (exp_q[0].wr) chkw("wdata_stable", mem_wdata, exp_q[0].wdata);
      end
      if (cnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_fn(mem_addr);
      end
      cmd_len = cnt;
      gap = 0;
    end else begin
      gap++;
    end
    if (spur_req) begin
      mem_ready = 1'b1;
      mem_rdata = '1;
      spur_req = 1'b0;
    end
    prev_cmd = cmd;
    if (ic_ready && dc_ready) begin
      checks++; errors++;
      $display("FAIL both_ready: got ic_ready=1 dc_ready=1 expected at most one");
    end
    if (ic_ready || dc_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready_unexpected: got ic=%b dc=%b expected none", ic_ready, dc_ready);
      end else begin
        t_mon = exp_q.pop_front();
        chkb("ready_port", dc_ready, t_mon.port);
        chkb("cmd_dropped", cmd, 1'b0);
        chki("cmd_len", cmd_len, mem_lat);
        if (!t_mon.port) ic_model = mem_fn(t_mon.addr);
        else if (!t_mon.wr) dc_model = mem_fn(t_mon.addr);
      end
    end
    chkw("ic_rdata", ic_rdata, ic_model);
    chkw("dc_rdata", dc_rdata, dc_model);
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((ic_read || dc_read || dc_write) && n < budget) begin
      @(negedge clk);
      n++;
      if (ic_ready) ic_read = 1'b0;
      if (dc_ready) begin dc_read = 1'b0; dc_write = 1'b0; end
    end
    if (ic_read || dc_read || dc_write) begin
      checks++; errors++;
      $display("FAIL wait_done: got request still pending after %0d cycles expected completion", budget);
      ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chkb("wait_busy", busy, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int dn, inn, n;
    bit dc_re, ic_re, seen;

    // reset state
    repeat (2) @(negedge clk);
    chkw("rst_ic_rdata", ic_rdata, '0);
    chkw("rst_dc_rdata", dc_rdata, '0);
    chka("rst_mem_addr", mem_addr, '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    chkb("rst_mem_read", mem_read, 1'b0);
    chkb("rst_mem_write", mem_write, 1'b0);
    chkb("rst_ic_ready", ic_ready, 1'b0);
    chkb("rst_dc_ready", dc_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    reset = 1'b1;

    // reset in the middle of a write-back
    @(negedge clk);
    mem_lat = 20;
    push(1'b1, 1'b1, 32'h0000_0700, {4{32'hA0A0_A0A0}});
    dc_write = 1'b1; dc_addr = 32'h0000_0700; dc_wdata = {4{32'hA0A0_A0A0}};
    wait_busy(5);
    chkb("pre_rst_mem_write", mem_write, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chkb("async_mem_write", mem_write, 1'b0);
    chkb("async_busy", busy, 1'b0);
    chka("async_mem_addr", mem_addr, '0);
    chkw("async_mem_wdata", mem_wdata, '0);
    dc_write = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chkb("post_rst_dc_ready", dc_ready, 1'b0);
      chkb("post_rst_busy", busy, 1'b0);
    end

    // table: last_grant after the reset is 0
    vecs[0] = '{1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0, 2, 1};
    vecs[1] = '{1, 0, 0, 32'h0000_0040, 32'h0, '0, 4, 0};
    vecs[2] = '{1, 1, 1, 32'h0000_0180, 32'h0000_0240, {4{32'h3333_CCCC}}, 3, 1};
    vecs[3] = '{0, 1, 0, 32'h0, 32'h0000_0280, '0, 1, 0};
    vecs[4] = '{1, 1, 0, 32'h0000_0140, 32'h0000_02C0, '0, 5, 0};
    vecs[5] = '{0, 0, 1, 32'h0, 32'h0000_0300, {4{32'h5555_0000}}, 2, 0};
    vecs[6] = '{1, 1, 0, 32'h0000_01C0, 32'h0000_0340, '0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_lat = vecs[i].lat;
      if (vecs[i].ic_r && (vecs[i].dc_r || vecs[i].dc_w)) begin
        if (vecs[i].d_first) begin
          push(1'b1, vecs[i].dc_w, vecs[i].dc_a, vecs[i].wd);
          push(1'b0, 1'b0, vecs[i].ic_a, '0);
        end else begin
          push(1'b0, 1'b0, vecs[i].ic_a, '0);
          push(1'b1, vecs[i].dc_w, vecs[i].dc_a, vecs[i].wd);
        end
      end else if (vecs[i].ic_r) begin
        push(1'b0, 1'b0, vecs[i].ic_a, '0);
      end else begin
        push(1'b1, vecs[i].dc_w, vecs[i].dc_a, vecs[i].wd);
      end
      ic_read = vecs[i].ic_r; ic_addr = vecs[i].ic_a;
      dc_read = vecs[i].dc_r; dc_write = vecs[i].dc_w;
      dc_addr = vecs[i].dc_a; dc_wdata = vecs[i].wd;
      wait_done(100);
      repeat (3) @(negedge clk);
      chki("queue_empty", exp_q.size(), 0);
    end

    // write-back with write data changing mid-transfer
    @(negedge clk);
    mem_lat = 4;
    push(1'b1, 1'b1, 32'h0000_0080, {4{32'h1111_1111}});
    dc_write = 1'b1; dc_addr = 32'h0000_0080; dc_wdata = {4{32'h1111_1111}};
    wait_busy(5);
    dc_wdata = {4{32'h2222_2222}};
    dc_addr = 32'h0000_0FF0;
    chkw("wb_mem_wdata", mem_wdata, {4{32'h1111_1111}});
    wait_done(50);
    repeat (3) @(negedge clk);
    chki("wb_queue_empty", exp_q.size(), 0);

    // starvation: D re-requests right after each completion while I holds
    do_reset();
    @(negedge clk);
    mem_lat = 3;
    push(1'b1, 1'b0, 32'h0000_0300, '0);
    push(1'b0, 1'b0, 32'h0000_0500, '0);
    push(1'b1, 1'b0, 32'h0000_0340, '0);
    push(1'b0, 1'b0, 32'h0000_0500, '0);
    ic_read = 1'b1; ic_addr = 32'h0000_0500;
    dc_read = 1'b1; dc_addr = 32'h0000_0300;
    dn = 0; inn = 0; dc_re = 1'b0; ic_re = 1'b0; n = 0;
    while ((dn < 2 || inn < 2) && n < 200) begin
      @(negedge clk);
      n++;
      if (dc_re) begin dc_read = 1'b1; dc_addr = 32'h0000_0340; dc_re = 1'b0; end
      if (ic_re) begin ic_read = 1'b1; ic_re = 1'b0; end
      if (dc_ready) begin dn++; dc_read = 1'b0; if (dn < 2) dc_re = 1'b1; end
      if (ic_ready) begin inn++; ic_read = 1'b0; if (inn < 2) ic_re = 1'b1; end
    end
    chki("starve_d_count", dn, 2);
    chki("starve_i_count", inn, 2);
    ic_read = 1'b0; dc_read = 1'b0;
    repeat (3) @(negedge clk);
    chki("starve_queue_empty", exp_q.size(), 0);

    // spurious mem_ready while idle
    @(negedge clk);
    spur_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("spur_busy", busy, 1'b0);
      chkb("spur_ic_ready", ic_ready, 1'b0);
      chkb("spur_dc_ready", dc_ready, 1'b0);
    end

    // I request dropped during the transfer still completes
    mem_lat = 3;
    push(1'b0, 1'b0, 32'h0000_0600, '0);
    ic_read = 1'b1; ic_addr = 32'h0000_0600;
    wait_busy(5);
    ic_read = 1'b0;
    ic_addr = 32'h0000_0EE0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ic_ready) seen = 1'b1;
    end
    chkb("late_drop_ic_ready", seen, 1'b1);
    repeat (3) @(negedge clk);
    chki("late_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
